// File: rtl/sum_bcd_pkg.sv
// Shared widths, FSM state type and the double-dabble nibble correction
// used by the BCD adder engine.
package sum_bcd_pkg;

    localparam int unsigned IN_W     = 12;
    localparam int unsigned SUM_W    = IN_W + 1;
    localparam int unsigned N_DIGITS = 4;
    localparam int unsigned BCD_W    = 4 * N_DIGITS;
    localparam int unsigned SR_W     = BCD_W + SUM_W;
    localparam int unsigned CNT_W    = $clog2(SUM_W);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        ADD,
        CONV,
        DONE
    } state_e;

    // Pre-shift correction so a nibble >= 5 carries correctly after doubling.
    function automatic logic [3:0] nibble_add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? 4'(nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/sum_bcd_if.sv
// Operand-entry and result bus between the digit-entry stage, the BCD adder
// engine and the display driver.
interface sum_bcd_if;
    import sum_bcd_pkg::*;

    logic                clear;
    logic [IN_W-1:0]     number_in;
    logic                in_ready;
    logic                operand_sel;
    logic                busy;
    logic [SUM_W-1:0]    sum_bin;
    logic [BCD_W-1:0]    bcd_out;
    logic                result_valid;

    modport master (
        output clear, number_in, in_ready,
        input  operand_sel, busy, sum_bin, bcd_out, result_valid
    );

    modport slave (
        input  clear, number_in, in_ready,
        output operand_sel, busy, sum_bin, bcd_out, result_valid
    );

endinterface

// File: rtl/sum_bcd_engine_bin2bcd_iter.sv
// Iterative shift-add-3 binary to BCD converter: SUM_W steps after load,
// done_c/bcd_c present the final digits during the last step.
module bin2bcd_iter
    import sum_bcd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              abort_i,
    input  logic [SUM_W-1:0]  bin_i,
    output logic              done_c,
    output logic [BCD_W-1:0]  bcd_c
);

    logic              running_q, running_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SR_W-1:0]   sreg_q, sreg_d;
    logic [SR_W-1:0]   sreg_corr;
    logic [SR_W-1:0]   sreg_shift;

    // One double-dabble step: correct every BCD nibble, then shift left.
    always_comb begin
        sreg_corr = sreg_q;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            sreg_corr[SUM_W + 4*i +: 4] = nibble_add3(sreg_q[SUM_W + 4*i +: 4]);
        end
        sreg_shift = sreg_corr << 1;
    end

    assign done_c = running_q && (cnt_q == CNT_W'(SUM_W - 1));
    assign bcd_c  = sreg_shift[SR_W-1 -: BCD_W];

    always_comb begin
        running_d = running_q;
        cnt_d     = cnt_q;
        sreg_d    = sreg_q;
        if (abort_i) begin
            running_d = 1'b0;
            cnt_d     = '0;
        end else if (load_i) begin
            running_d = 1'b1;
            cnt_d     = '0;
            sreg_d    = {BCD_W'(0), bin_i};
        end else if (running_q) begin
            sreg_d = sreg_shift;
            cnt_d  = CNT_W'(cnt_q + 1'b1);
            if (done_c) begin
                running_d = 1'b0;
                cnt_d     = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            sreg_q    <= '0;
        end else begin
            running_q <= running_d;
            cnt_q     <= cnt_d;
            sreg_q    <= sreg_d;
        end
    end

endmodule

// File: rtl/sum_bcd_engine.sv
// Captures two operands on in_ready rising edges, adds them and publishes
// the binary sum plus its packed-BCD form 14 cycles after operand B.
module sum_bcd_engine
    import sum_bcd_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    sum_bcd_if.slave  bus
);

    localparam int unsigned DEC_RANGE = 10 ** N_DIGITS;
    localparam int unsigned MAX_SUM   = (32'd1 << SUM_W) - 32'd1;

    if (DEC_RANGE <= MAX_SUM) begin : g_range_err
        $error("N_DIGITS cannot represent the largest SUM_W value");
    end

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [IN_W-1:0]   op_a_q, op_a_d;
    logic [IN_W-1:0]   op_b_q, op_b_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [SUM_W-1:0]  sum_bin_q, sum_bin_d;
    logic [BCD_W-1:0]  bcd_out_q, bcd_out_d;
    logic              result_valid_q, result_valid_d;
    logic              busy_q, busy_d;
    logic              operand_sel_q, operand_sel_d;

    logic              cap_c;
    logic              conv_load_c;
    logic              conv_abort_c;
    logic              conv_done_c;
    logic [BCD_W-1:0]  conv_bcd_c;

    assign cap_c = bus.in_ready & ~in_ready_q;

    bin2bcd_iter u_bin2bcd (
        .clk     (clk),
        .rst_n   (reset),
        .load_i  (conv_load_c),
        .abort_i (conv_abort_c),
        .bin_i   (sum_d),
        .done_c  (conv_done_c),
        .bcd_c   (conv_bcd_c)
    );

    // Next-state, operand capture and result publication.
    always_comb begin
        state_d        = state_q;
        in_ready_d     = bus.in_ready;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        sum_d          = sum_q;
        sum_bin_d      = sum_bin_q;
        bcd_out_d      = bcd_out_q;
        result_valid_d = result_valid_q;
        conv_load_c    = 1'b0;
        conv_abort_c   = 1'b0;

        if (bus.clear) begin
            state_d        = WAIT_A;
            result_valid_d = 1'b0;
            sum_bin_d      = '0;
            bcd_out_d      = '0;
            conv_abort_c   = 1'b1;
        end else begin
            unique case (state_q)
                WAIT_A, DONE: begin
                    if (cap_c) begin
                        op_a_d         = bus.number_in;
                        result_valid_d = 1'b0;
                        state_d        = WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (cap_c) begin
                        op_b_d  = bus.number_in;
                        state_d = ADD;
                    end
                end
                ADD: begin
                    sum_d       = SUM_W'(op_a_q) + SUM_W'(op_b_q);
                    conv_load_c = 1'b1;
                    state_d     = CONV;
                end
                CONV: begin
                    if (conv_done_c) begin
                        sum_bin_d      = sum_q;
                        bcd_out_d      = conv_bcd_c;
                        result_valid_d = 1'b1;
                        state_d        = DONE;
                    end
                end
                default: state_d = WAIT_A;
            endcase
        end

        busy_d        = (state_d == ADD) || (state_d == CONV);
        operand_sel_d = (state_d == WAIT_B);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= WAIT_A;
            in_ready_q     <= 1'b0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            sum_q          <= '0;
            sum_bin_q      <= '0;
            bcd_out_q      <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            operand_sel_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            in_ready_q     <= in_ready_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            sum_q          <= sum_d;
            sum_bin_q      <= sum_bin_d;
            bcd_out_q      <= bcd_out_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            operand_sel_q  <= operand_sel_d;
        end
    end

    assign bus.operand_sel  = operand_sel_q;
    assign bus.busy         = busy_q;
    assign bus.sum_bin      = sum_bin_q;
    assign bus.bcd_out      = bcd_out_q;
    assign bus.result_valid = result_valid_q;

endmodule

// File: tb/tb_sum_bcd_engine.sv
// Scenario bench for sum_bcd_engine: expected sums/BCD queued at operand B,
// popped and compared when result_valid rises.
module tb_sum_bcd_engine;
    import sum_bcd_pkg::*;

    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic [BCD_W-1:0] bcd;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    sum_bcd_if bus();

    sum_bcd_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    function automatic logic [BCD_W-1:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Operand A: one-cycle pulse, then one idle cycle so the next edge is seen.
    task automatic send_a(input int a);
        @(negedge clk);
        bus.number_in = IN_W'(a);
        bus.in_ready  = 1'b1;
        @(posedge clk);
        #1 bus.in_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Operand B: returns #1 after the capturing edge and queues the expectation.
    task automatic send_b(input int a, input int b, input bit expect_result);
        exp_t e;
        @(negedge clk);
        bus.number_in = IN_W'(b);
        bus.in_ready  = 1'b1;
        if (expect_result) begin
            e.sum = SUM_W'(a + b);
            e.bcd = to_bcd(a + b);
            sb.push_back(e);
        end
        @(posedge clk);
        #1 bus.in_ready = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.result_valid && n < 40);
    endtask

    task automatic test_reset();
        tests_run++;
        if ({bus.result_valid, bus.busy, bus.operand_sel} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b exp 000", {bus.result_valid, bus.busy, bus.operand_sel});
        end
        tests_run++;
        if (bus.sum_bin !== '0) begin
            tests_failed++;
            $display("FAIL reset_sum: got %0d exp 0", bus.sum_bin);
        end
        tests_run++;
        if (bus.bcd_out !== '0) begin
            tests_failed++;
            $display("FAIL reset_bcd: got %h exp 0000", bus.bcd_out);
        end
    endtask

    task automatic test_basic();
        int   lat;
        exp_t e;
        send_a(123);
        tests_run++;
        if (bus.operand_sel !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_sel_after_a: got %b exp 1", bus.operand_sel);
        end
        send_b(123, 456, 1'b1);
        tests_run++;
        if ({bus.operand_sel, bus.busy} !== 2'b01) begin
            tests_failed++;
            $display("FAIL basic_sel_busy_after_b: got %b exp 01", {bus.operand_sel, bus.busy});
        end
        wait_valid(lat);
        tests_run++;
        if (lat != 14) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d exp 14", lat);
        end
        e = sb.pop_front();
        tests_run++;
        if (bus.sum_bin !== e.sum) begin
            tests_failed++;
            $display("FAIL basic_sum: got %0d exp %0d", bus.sum_bin, e.sum);
        end
        tests_run++;
        if (bus.bcd_out !== e.bcd) begin
            tests_failed++;
            $display("FAIL basic_bcd: got %h exp %h", bus.bcd_out, e.bcd);
        end
        tests_run++;
        if ({bus.operand_sel, bus.busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL basic_sel_busy_done: got %b exp 00", {bus.operand_sel, bus.busy});
        end
    endtask

    task automatic test_back_to_back();
        int   av[7];
        int   bv[7];
        int   lat;
        exp_t e;
        av = '{999, 0, 4095, 1, 0, 0, 0};
        bv = '{999, 0, 4095, 9, 0, 0, 0};
        for (int i = 4; i < 7; i++) begin
            av[i] = int'($urandom_range(0, 4095));
            bv[i] = int'($urandom_range(0, 4095));
        end
        for (int i = 0; i < 7; i++) begin
            send_a(av[i]);
            tests_run++;
            if (bus.result_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_valid_drop[%0d]: got %b exp 0", i, bus.result_valid);
            end
            send_b(av[i], bv[i], 1'b1);
            wait_valid(lat);
            tests_run++;
            if (lat != 14) begin
                tests_failed++;
                $display("FAIL b2b_latency[%0d]: got %0d exp 14", i, lat);
            end
            e = sb.pop_front();
            tests_run++;
            if (bus.sum_bin !== e.sum) begin
                tests_failed++;
                $display("FAIL b2b_sum[%0d] %0d+%0d: got %0d exp %0d", i, av[i], bv[i], bus.sum_bin, e.sum);
            end
            tests_run++;
            if (bus.bcd_out !== e.bcd) begin
                tests_failed++;
                $display("FAIL b2b_bcd[%0d] %0d+%0d: got %h exp %h", i, av[i], bv[i], bus.bcd_out, e.bcd);
            end
        end
    endtask

    task automatic test_hold_and_ignore();
        int   lat;
        int   bad;
        exp_t e;
        @(negedge clk);
        bus.number_in = IN_W'(300);
        bus.in_ready  = 1'b1;
        @(posedge clk);
        #1 bus.number_in = IN_W'(777);
        repeat (19) @(posedge clk);
        #1;
        tests_run++;
        if ({bus.operand_sel, bus.busy} !== 2'b10) begin
            tests_failed++;
            $display("FAIL hold_still_wait_b: got %b exp 10", {bus.operand_sel, bus.busy});
        end
        bus.in_ready = 1'b0;
        @(posedge clk);
        #1;
        send_b(300, 100, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        bus.number_in = IN_W'(2000);
        bus.in_ready  = 1'b1;
        @(posedge clk);
        #1 bus.in_ready = 1'b0;
        wait_valid(lat);
        tests_run++;
        if (lat != 10) begin
            tests_failed++;
            $display("FAIL hold_latency: got %0d exp 10", lat);
        end
        e = sb.pop_front();
        tests_run++;
        if ({bus.sum_bin, bus.bcd_out} !== {e.sum, e.bcd}) begin
            tests_failed++;
            $display("FAIL hold_result: got %0d/%h exp %0d/%h", bus.sum_bin, bus.bcd_out, e.sum, e.bcd);
        end
        bad = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (!bus.result_valid || bus.operand_sel) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL hold_done_stable: got %0d bad cycles exp 0", bad);
        end
    endtask

    task automatic test_clear();
        int   lat;
        int   bad;
        exp_t e;
        send_a(5);
        send_b(5, 6, 1'b0);
        repeat (6) @(posedge clk);
        #1 bus.clear = 1'b1;
        @(posedge clk);
        #1 bus.clear = 1'b0;
        tests_run++;
        if ({bus.result_valid, bus.busy, bus.operand_sel} !== 3'b000) begin
            tests_failed++;
            $display("FAIL clear_flags: got %b exp 000", {bus.result_valid, bus.busy, bus.operand_sel});
        end
        tests_run++;
        if ({bus.sum_bin, bus.bcd_out} !== '0) begin
            tests_failed++;
            $display("FAIL clear_outputs: got %0d/%h exp 0/0000", bus.sum_bin, bus.bcd_out);
        end
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.result_valid || bus.busy) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL clear_no_leak: got %0d bad cycles exp 0", bad);
        end
        send_a(7);
        send_b(7, 8, 1'b1);
        wait_valid(lat);
        e = sb.pop_front();
        tests_run++;
        if (lat != 14 || bus.bcd_out !== e.bcd || bus.sum_bin !== e.sum) begin
            tests_failed++;
            $display("FAIL clear_then_op: got lat %0d %0d/%h exp lat 14 %0d/%h", lat, bus.sum_bin, bus.bcd_out, e.sum, e.bcd);
        end
    endtask

    task automatic test_async_reset();
        int   lat;
        exp_t e;
        send_a(1234);
        send_b(1234, 1000, 1'b0);
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if ({bus.result_valid, bus.busy, bus.operand_sel} !== 3'b000) begin
            tests_failed++;
            $display("FAIL areset_flags: got %b exp 000", {bus.result_valid, bus.busy, bus.operand_sel});
        end
        tests_run++;
        if ({bus.sum_bin, bus.bcd_out} !== '0) begin
            tests_failed++;
            $display("FAIL areset_outputs: got %0d/%h exp 0/0000", bus.sum_bin, bus.bcd_out);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        send_a(250);
        send_b(250, 250, 1'b1);
        wait_valid(lat);
        e = sb.pop_front();
        tests_run++;
        if (lat != 14 || bus.bcd_out !== e.bcd || bus.sum_bin !== e.sum) begin
            tests_failed++;
            $display("FAIL areset_then_op: got lat %0d %0d/%h exp lat 14 %0d/%h", lat, bus.sum_bin, bus.bcd_out, e.sum, e.bcd);
        end
    endtask

    initial begin
        reset         = 1'b0;
        bus.clear     = 1'b0;
        bus.in_ready  = 1'b0;
        bus.number_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        test_reset();
        test_basic();
        test_back_to_back();
        test_hold_and_ignore();
        test_clear();
        test_async_reset();

        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d left exp 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
